// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: shared encodings and constants for the HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;
    typedef enum logic [1:0] {OP_MULTU = 2'd0, OP_MULT = 2'd1, OP_DIVU = 2'd2, OP_DIV = 2'd3} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;
    localparam int ITERATIONS = 32;
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFFFFFF;
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
        return signed_op && v[31] ? -v : v;
    endfunction
endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// mips_cpu_muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on {a,q}.
module mips_cpu_muldiv_step (
    input  logic        is_div,
    input  logic [31:0] a_in,
    input  logic [31:0] q_in,
    input  logic [31:0] m,
    output logic [31:0] a_out,
    output logic [31:0] q_out
);
    logic [32:0] sum, shl, diff;
    // Divide keeps a < m, so a non-negative diff never sets bit 32 for a non-zero divisor.
    always_comb begin
        sum   = {1'b0, a_in} + (q_in[0] ? {1'b0, m} : 33'd0);
        shl   = {a_in, q_in[31]};
        diff  = shl - {1'b0, m};
        a_out = is_div ? (diff[32] ? shl[31:0] : diff[31:0]) : sum[32:1];
        q_out = is_div ? {q_in[30:0], ~diff[32]} : {sum[0], q_in[31:1]};
    end
endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// mips_cpu_muldiv_ctrl: fixed 33-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
module mips_cpu_muldiv_ctrl
    import mips_cpu_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mt_en,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        mf_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    state_e      state, state_nx;
    op_e         op_q;
    logic [5:0]  cnt;
    logic [31:0] a, q, m, rs_q, a_nx, q_nx, quo, rem;
    logic        neg_q, neg_r, dbz, is_div;
    logic [63:0] prod, res;

    assign is_div = op_q == OP_DIVU || op_q == OP_DIV;

    mips_cpu_muldiv_step u_step (
        .is_div (is_div),
        .a_in   (a),
        .q_in   (q),
        .m      (m),
        .a_out  (a_nx),
        .q_out  (q_nx)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state == S_IDLE ? (start ? S_ITER : S_IDLE) :
                   state == S_ITER ? (cnt == 6'(ITERATIONS - 1) ? S_FIX : S_ITER) : S_IDLE;
    end

    always_comb begin
        busy  = state != S_IDLE;
        stall = mf_req & busy;
    end

    // Signs are stripped at issue and restored here; neg_q/neg_r are only ever set for signed ops.
    always_comb begin
        prod = op_q == OP_MULT && neg_q ? -{a, q} : {a, q};
        quo  = op_q == OP_DIV && neg_q ? -q : q;
        rem  = op_q == OP_DIV && neg_r ? -a : a;
        res  = !is_div ? prod : dbz ? {rs_q, DIV_BY_ZERO_LO} : {rem, quo};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_MULTU;
            cnt   <= '0;
            a     <= '0;
            q     <= '0;
            m     <= '0;
            rs_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= state == S_FIX;
            if (state == S_IDLE && start) begin
                op_q  <= op_e'(op);
                cnt   <= '0;
                a     <= '0;
                q     <= mag32(rs_data, op[0]);
                m     <= mag32(rt_data, op[0]);
                rs_q  <= rs_data;
                neg_q <= op[0] & (rs_data[31] ^ rt_data[31]);
                neg_r <= op[0] & rs_data[31];
                dbz   <= op[1] & (rt_data == '0);
            end else if (state == S_IDLE && mt_en) begin
                if (mt_sel) hi <= mt_data;
                else        lo <= mt_data;
            end else if (state == S_ITER) begin
                a   <= a_nx;
                q   <= q_nx;
                cnt <= cnt + 6'd1;
            end else if (state == S_FIX) begin
                {hi, lo} <= res;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// tb_mips_cpu_muldiv_ctrl: scoreboard bench for the multiply/divide sequencer.
module tb_mips_cpu_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, mt_en, mt_sel, mf_req;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, mt_data, hi, lo;
    logic        busy, done, stall;
    logic [63:0] sb_q[$];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    mips_cpu_muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mt_en   (mt_en),
        .mt_sel  (mt_sel),
        .mt_data (mt_data),
        .mf_req  (mf_req),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference {HI,LO} from native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        if (o == 2'd0) return {32'd0, x} * {32'd0, y};
        if (o == 2'd1) return 64'(sx * sy);
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == 2'd2) return {x % y, x / y};
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input bit mf, input bit poke, input bit mt_same);
        logic [63:0] prev;
        int n;
        bit busy_ok, stall_ok, hold_ok;
        prev = {hi, lo};
        op = o; rs_data = x; rt_data = y; start = 1'b1; mf_req = mf;
        mt_en = mt_same; mt_sel = 1'b1; mt_data = 32'h99;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; mt_en = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        busy_ok = busy; stall_ok = stall == mf; hold_ok = 1'b1; n = 0;
        while (!done && n < 40) begin
            if (poke && n == 5) begin
                start = 1'b1; op = ~o; mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'hAAAA;
            end else begin
                start = 1'b0; mt_en = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (!done) begin
                busy_ok &= busy;
                stall_ok &= stall == mf;
                hold_ok &= {hi, lo} == prev;
            end
        end
        start = 1'b0; mt_en = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_stall"}, 64'(stall_ok), 64'd1);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_idle"}, {62'd0, busy, stall}, 64'd0);
        check({tag, "_result"}, {hi, lo}, sb_q.size() > 0 ? sb_q.pop_front() : 64'hDEAD);
        mf_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        mt_en = 1'b0; mt_sel = 1'b0; mt_data = '0; mf_req = 1'b0;
        #3;
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("divu_15_5", 2'd2, 32'd15, 32'd5, 64'h00000000_00000003, 1'b0, 1'b0, 1'b0);
        run_op("div_m7_2", 2'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0, 1'b0);
        run_op("div_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0, 1'b0);
        run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0, 1'b0);
        run_op("mult_m1", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 1'b0, 1'b0);
        run_op("divu_dbz", 2'd2, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("div_dbz", 2'd3, 32'hFFFF0000, 32'd0, 64'hFFFF0000_FFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("mult_neg", 2'd1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0, 1'b0);
        run_op("divu_stall", 2'd2, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1, 1'b1, 1'b0);
        run_op("mt_vs_start", 2'd0, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0] o;
            logic [31:0] x, y;
            o = i[1:0];
            x = $urandom;
            y = $urandom;
            if (o[1]) y = y >> $urandom_range(0, 31);
            run_op("rand", o, x, y, model(o, x, y), 1'b0, 1'b0, 1'b0);
        end

        // Abort mid-operation with an asynchronous reset.
        op = 2'd2; rs_data = 32'd500; rt_data = 32'd3; start = 1'b1;
        sb_q.push_back(model(2'd2, 32'd500, 32'd3));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_flags", {62'd0, busy, done}, 64'd0);
        void'(sb_q.pop_front());
        @(posedge clk); #1;
        reset = 1'b0;
        mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h55;
        @(posedge clk); #1;
        mt_en = 1'b0;
        check("mtlo", {hi, lo}, 64'h00000000_00000055);
        mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'h77;
        @(posedge clk); #1;
        mt_en = 1'b0;
        check("mthi", {hi, lo}, 64'h00000077_00000055);
        run_op("post_reset", 2'd3, 32'd9, 32'hFFFFFFFE, model(2'd3, 32'd9, 32'hFFFFFFFE), 1'b0, 1'b0, 1'b0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
